clkgen_multi: RTL
=================

// Module: clkgen_multi
// PURPOSE
//   Synthesizable NUM_CH-channel clock generator driven from one reference clock.
//   Each channel has its own divide ratio, high time and start phase.
//   Each channel has glitch-free start/stop.
//   Sits in testbenches and in FPGA test harnesses as the next generation of our
//   free-running clock model.
//   Configuration uses a valid/ready port; new settings take effect only on a period boundary.
// PARAMETERS
//   NUM_CH    4   number of generated clock channels (1..16)
//   DIV_W     8   width of divide, high-time and phase fields
//   DEF_DIV   8   period after reset, in clk cycles (2..2**DIV_W-1)
//   DEF_HIGH  4   high time after reset, in clk cycles (1..DEF_DIV-1)
// PORTS
//   clk         in   1                reference clock; all logic on posedge
//   rst_n       in   1                synchronous reset, active low
//   en_i        in   NUM_CH           per-channel run enable (level)
//   sync_i      in   1                pulse: restart all running channels together
//   cfg_valid   in   1                config request
//   cfg_ready   out  1                config accepted when valid&&ready
//   cfg_ch      in   $clog2(NUM_CH)   target channel
//   cfg_div     in   DIV_W            period in clk cycles
//   cfg_high    in   DIV_W            high time in clk cycles
//   cfg_phase   in   DIV_W            delay from start to first rising edge
//   cfg_err     out  1                1-cycle pulse: request rejected
//   clk_o       out  NUM_CH           generated clocks (registered)
//   rise_o      out  NUM_CH           1-cycle pulse in the cycle clk_o goes 0->1
//   running_o   out  NUM_CH           channel in PHASE/RUN/DRAIN
// BEHAVIOUR
//   Reset
//     - rst_n=0 sampled at a posedge: all outputs go to 0 except cfg_ready, which goes to 1.
//     - All channels go to IDLE and cnt=0.
//     - Active settings become div=DEF_DIV, high=DEF_HIGH, phase=0; pending shadows are cleared.
//     - Reset mid-period cuts clk_o low on the next edge. This is the only permitted truncated pulse.
//   Per-channel FSM
//     - IDLE: en_i=1 -> PHASE with pcnt=phase.
//     - PHASE: pcnt decrements each cycle; at 0 -> RUN with cnt=0.
//       - phase=0 skips PHASE entirely.
//       - Result: en_i sampled high at cycle t gives clk_o=1 at t+1+phase.
//     - RUN: cnt counts 0..div-1 and wraps; clk_o = (cnt < high).
//       - rise_o=1 on every cycle where cnt==0.
//     - RUN with en_i=0 -> DRAIN: keep counting until cnt==div-1, then -> IDLE with clk_o=0.
//       - Always a whole period; never a short high or low phase.
//     - DRAIN with en_i=1 -> back to RUN, with no disturbance to cnt.
//     - PHASE with en_i=0 -> IDLE immediately; no edge is produced.
//   sync_i
//     - Every channel in RUN or DRAIN reloads pcnt=phase and enters PHASE.
//     - Every channel in PHASE restarts pcnt=phase.
//     - Channels in IDLE are unaffected.
//     - If a channel is high when sync_i arrives, clk_o drops low on the next edge.
//     - sync_i has priority over en_i falling in the same cycle.
//   Configuration
//     - Legal request: 2 <= div, 1 <= high <= div-1, cfg_ch < NUM_CH.
//     - An illegal request is still accepted (handshake completes), with cfg_err=1 next cycle and no state change.
//     - A legal request is written to that channel's shadow and marked pending.
//     - cfg_ready = !pending[cfg_ch] (combinational on cfg_ch).
//     - Shadow -> active transfer:
//       - Channel in IDLE: the cycle after acceptance.
//       - Channel in PHASE/RUN/DRAIN: on the cycle cnt wraps from div-1 to 0 (the new period starts with the new values).
//     - New phase is used on the next IDLE->PHASE or sync_i only.
//     - Transfer and a new accept for the same channel in the same cycle: the transfer wins; ready is re-evaluated next cycle.
//   Widths: all counters are DIV_W bits and never overflow, given the legal ranges above.
// TESTING
//   1. Reset then en_i[0]=1 at t -> clk_o[0] high t+1..t+4, low t+5..t+8; period 8; rise_o[0] at t+1, t+9.
//   2. cfg ch1 div=5 high=2 phase=3; en_i[1]=1 at t -> first rise at t+4; pattern 11000 repeats.
//   3. Ch0 running div=8: write div=3 high=1 mid-period -> cfg_ready low until wrap.
//      - Current period completes at 8; next period is 100.
//   4. Drop en_i[0] at cnt=2 -> clk_o[0] finishes 11110000 then stays 0; running_o[0] falls with the last low cycle.
//      - Re-raising en_i during DRAIN -> no gap.
//   5. Ch0 and ch1 both running, with phases 0 and 2; pulse sync_i -> ch0 rise at +1, ch1 rise at +3.
//   6. Illegal requests -> cfg_err=1, no change:
//      - div=1.
//      - high=0.
//      - high=div.
//      - cfg_ch=NUM_CH (when NUM_CH < 2**$clog2(NUM_CH)).
//   Also: rst_n low for 1 cycle mid-RUN -> all outputs 0 next cycle; default settings restored.

Source files
------------

// File: rtl/clkgen_multi.sv
// Multi-channel clock generator: per-channel divide/high/phase with glitch-free
// start/stop and shadowed configuration applied on period boundaries.
module clkgen_multi #(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned DIV_W    = 8,
  parameter int unsigned DEF_DIV  = 8,
  parameter int unsigned DEF_HIGH = 4,
  localparam int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] en_i,
  input  logic              sync_i,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [DIV_W-1:0]  cfg_high,
  input  logic [DIV_W-1:0]  cfg_phase,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] clk_o,
  output logic [NUM_CH-1:0] rise_o,
  output logic [NUM_CH-1:0] running_o
);

  typedef enum logic [1:0] {StIdle, StPhase, StRun, StDrain} ch_state_e;

  ch_state_e        st_q     [NUM_CH];
  ch_state_e        st_d     [NUM_CH];
  logic [DIV_W-1:0] cnt_q    [NUM_CH];
  logic [DIV_W-1:0] cnt_d    [NUM_CH];
  logic [DIV_W-1:0] pcnt_q   [NUM_CH];
  logic [DIV_W-1:0] pcnt_d   [NUM_CH];
  logic [DIV_W-1:0] div_q    [NUM_CH];
  logic [DIV_W-1:0] div_d    [NUM_CH];
  logic [DIV_W-1:0] high_q   [NUM_CH];
  logic [DIV_W-1:0] high_d   [NUM_CH];
  logic [DIV_W-1:0] phase_q  [NUM_CH];
  logic [DIV_W-1:0] phase_d  [NUM_CH];
  logic [DIV_W-1:0] sdiv_q   [NUM_CH];
  logic [DIV_W-1:0] sdiv_d   [NUM_CH];
  logic [DIV_W-1:0] shigh_q  [NUM_CH];
  logic [DIV_W-1:0] shigh_d  [NUM_CH];
  logic [DIV_W-1:0] sphase_q [NUM_CH];
  logic [DIV_W-1:0] sphase_d [NUM_CH];

  logic [NUM_CH-1:0] pend_q, pend_d;
  logic [NUM_CH-1:0] wrap, xfer, restart, live_d;
  logic [NUM_CH-1:0] clk_q, clk_d, rise_q, rise_d, running_q, running_d;
  logic              err_q, err_d;
  logic              cfg_acc, cfg_legal;

  assign clk_o     = clk_q;
  assign rise_o    = rise_q;
  assign running_o = running_q;
  assign cfg_err   = err_q;

  // Out-of-range channels read as ready so illegal requests still complete.
  always_comb begin
    cfg_ready = 1'b1;
    for (int c = 0; c < NUM_CH; c++) begin
      if (cfg_ch == CH_W'(c)) cfg_ready = ~pend_q[c];
    end
  end

  always_comb begin
    cfg_acc   = cfg_valid & cfg_ready;
    cfg_legal = (cfg_div >= DIV_W'(2)) && (cfg_high != '0) && (cfg_high < cfg_div) &&
                (32'(cfg_ch) < NUM_CH);
    err_d     = cfg_acc & ~cfg_legal;
    for (int c = 0; c < NUM_CH; c++) begin
      st_d[c]     = st_q[c];
      cnt_d[c]    = cnt_q[c];
      pcnt_d[c]   = pcnt_q[c];
      div_d[c]    = div_q[c];
      high_d[c]   = high_q[c];
      phase_d[c]  = phase_q[c];
      sdiv_d[c]   = sdiv_q[c];
      shigh_d[c]  = shigh_q[c];
      sphase_d[c] = sphase_q[c];
      pend_d[c]   = pend_q[c];
      restart[c]  = 1'b0;

      wrap[c] = ((st_q[c] == StRun) || (st_q[c] == StDrain)) &&
                (cnt_q[c] == div_q[c] - DIV_W'(1));
      xfer[c] = pend_q[c] && ((st_q[c] == StIdle) || wrap[c]);

      if (xfer[c]) begin
        div_d[c]   = sdiv_q[c];
        high_d[c]  = shigh_q[c];
        phase_d[c] = sphase_q[c];
        pend_d[c]  = 1'b0;
      end else if (cfg_acc && cfg_legal && (cfg_ch == CH_W'(c))) begin
        sdiv_d[c]   = cfg_div;
        shigh_d[c]  = cfg_high;
        sphase_d[c] = cfg_phase;
        pend_d[c]   = 1'b1;
      end

      unique case (st_q[c])
        StIdle: restart[c] = en_i[c];
        StPhase: begin
          if (sync_i) begin
            restart[c] = 1'b1;
          end else if (!en_i[c]) begin
            st_d[c] = StIdle;
          end else if (pcnt_q[c] <= DIV_W'(1)) begin
            st_d[c]  = StRun;
            cnt_d[c] = '0;
          end else begin
            pcnt_d[c] = pcnt_q[c] - DIV_W'(1);
          end
        end
        StRun, StDrain: begin
          if (sync_i) begin
            restart[c] = 1'b1;
          end else if (!en_i[c] && wrap[c]) begin
            st_d[c]  = StIdle;
            cnt_d[c] = '0;
          end else begin
            st_d[c]  = en_i[c] ? StRun : StDrain;
            cnt_d[c] = wrap[c] ? '0 : cnt_q[c] + DIV_W'(1);
          end
        end
      endcase

      // Zero phase starts the first period immediately.
      if (restart[c]) begin
        cnt_d[c]  = '0;
        pcnt_d[c] = phase_d[c];
        st_d[c]   = (phase_d[c] == '0) ? StRun : StPhase;
      end

      live_d[c]    = (st_d[c] == StRun) || (st_d[c] == StDrain);
      clk_d[c]     = live_d[c] && (cnt_d[c] < high_d[c]);
      rise_d[c]    = live_d[c] && (cnt_d[c] == '0);
      running_d[c] = (st_d[c] != StIdle);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        st_q[c]     <= StIdle;
        cnt_q[c]    <= '0;
        pcnt_q[c]   <= '0;
        div_q[c]    <= DIV_W'(DEF_DIV);
        high_q[c]   <= DIV_W'(DEF_HIGH);
        phase_q[c]  <= '0;
        sdiv_q[c]   <= '0;
        shigh_q[c]  <= '0;
        sphase_q[c] <= '0;
      end
      pend_q    <= '0;
      err_q     <= 1'b0;
      clk_q     <= '0;
      rise_q    <= '0;
      running_q <= '0;
    end else begin
      st_q      <= st_d;
      cnt_q     <= cnt_d;
      pcnt_q    <= pcnt_d;
      div_q     <= div_d;
      high_q    <= high_d;
      phase_q   <= phase_d;
      sdiv_q    <= sdiv_d;
      shigh_q   <= shigh_d;
      sphase_q  <= sphase_d;
      pend_q    <= pend_d;
      err_q     <= err_d;
      clk_q     <= clk_d;
      rise_q    <= rise_d;
      running_q <= running_d;
    end
  end

endmodule
